// File: rtl/fp_convert_sched_if.sv
// Request/result bundle for fp_convert_sched: per-requester samples in, tagged float results out.
// slave is the converter side, master is the requester/consumer side.
interface fp_convert_sched_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [12*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                out_valid;
  logic                out_ready;
  logic                out_s;
  logic [2:0]          out_e;
  logic [3:0]          out_f;
  logic [IDW-1:0]      out_id;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_s, out_e, out_f, out_id
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_s, out_e, out_f, out_id
  );
endinterface

// File: rtl/fp_convert_sched.sv
// Round-robin shared 12-bit two's-complement to 1/3/4 float converter with id-tagged results.
// Optional build macro FPCONV_FAST_SCAN_EN: one-cycle normalisation instead of one shift per cycle.
module fp_convert_sched #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input logic               clk,
  input logic               rst,
  fp_convert_sched_if.slave bus
);
  localparam int DATA_W = 12;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, ROUND, OUT} state_t;

  state_t                    state;
  logic [IDW-1:0]            ptr;
  logic signed [DATA_W-1:0]  sample;
  logic [IDW-1:0]            cur_id;
  logic                      sign;
  logic [DATA_W-2:0]         mag;
  logic [2:0]                ex;
  logic                      res_valid;
  logic                      res_s;
  logic [2:0]                res_e;
  logic [3:0]                res_f;
  logic [IDW-1:0]            res_id;

  logic                      pick_any;
  logic [IDW-1:0]            pick_id;
  logic [IDW-1:0]            cand;
  logic                      grant_en;
  logic [DATA_W-1:0]         req_word [N_REQ];

  // |x| on 11 bits; the single unrepresentable magnitude (-2048) clips to 2047.
  function automatic logic [DATA_W-2:0] sat_mag(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    if (x[DATA_W-1] && (x[DATA_W-2:0] == '0)) return '1;
    return x[DATA_W-1] ? neg[DATA_W-2:0] : x[DATA_W-2:0];
  endfunction

  // Round half-up on mag[6]; a carry out of F renormalises, or saturates at the top exponent.
  function automatic logic [6:0] round_fp(input logic [DATA_W-2:0] m, input logic [2:0] e);
    logic [3:0] f;
    logic       r;
    f = m[10:7];
    r = m[6];
    if (r && (f == 4'hF)) return (e == 3'd7) ? {3'd7, 4'hF} : {e + 3'd1, 4'h8};
    return {e, f + {3'b000, r}};
  endfunction

`ifdef FPCONV_FAST_SCAN_EN
  // Left shift that brings the leading one to bit 10, capped at 7 (E cannot go below 0).
  function automatic logic [2:0] lead_shift(input logic [DATA_W-2:0] m);
    logic [2:0] s;
    s = 3'd7;
    for (int i = 3; i <= 10; i++) begin
      if (m[i]) s = 3'(10 - i);
    end
    return s;
  endfunction
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_port
    assign req_word[g]      = bus.req_data[g*DATA_W +: DATA_W];
    assign bus.req_ready[g] = grant_en && (pick_id == IDW'(g));
  end

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    pick_any = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % N_REQ);
      if (!pick_any && bus.req_valid[cand]) begin
        pick_any = 1'b1;
        pick_id  = cand;
      end
    end
  end

  assign grant_en = (state == IDLE) && !rst && pick_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      res_valid <= 1'b0;
      res_s     <= 1'b0;
      res_e     <= '0;
      res_f     <= '0;
      res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            sample <= $signed(req_word[pick_id]);
            cur_id <= pick_id;
            ptr    <= (pick_id == IDW'(N_REQ - 1)) ? '0 : pick_id + 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          sign  <= sample[DATA_W-1];
          mag   <= sat_mag(sample);
          ex    <= 3'd7;
          state <= SCAN;
        end
        SCAN: begin
`ifdef FPCONV_FAST_SCAN_EN
          mag   <= mag << lead_shift(mag);
          ex    <= 3'd7 - lead_shift(mag);
          state <= ROUND;
`else
          if (mag[10] || (ex == 3'd0)) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            ex  <= ex - 3'd1;
          end
`endif
        end
        ROUND: begin
          {res_e, res_f} <= round_fp(mag, ex);
          res_s          <= sign;
          res_id         <= cur_id;
          res_valid      <= 1'b1;
          state          <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = res_valid;
  assign bus.out_s     = res_s;
  assign bus.out_e     = res_e;
  assign bus.out_f     = res_f;
  assign bus.out_id    = res_id;
endmodule

// File: tb/tb_fp_convert_sched.sv
// Bench for fp_convert_sched: directed vectors, round-robin order, back-pressure, reset abort, random traffic.
module tb_fp_convert_sched;
  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_convert_sched_if #(.N_REQ(N_REQ), .IDW(IDW)) bus ();
  fp_convert_sched #(.N_REQ(N_REQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference: value = F*2^E, E chosen so that |x| < 16*2^E, F rounded half-up.
  function automatic void model(input logic [11:0] x, output logic [7:0] res, output int lat);
    int v, m, ep, fr;
    v = int'($signed(x));
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    ep = 0;
    while (ep < 7 && m >= (16 << ep)) ep++;
`ifdef FPCONV_FAST_SCAN_EN
    lat = 3;
`else
    lat = 3 + (7 - ep);
`endif
    fr = (ep > 0) ? ((m + (1 << (ep - 1))) >> ep) : m;
    if (fr == 16) begin
      if (ep == 7) fr = 15;
      else begin
        fr = 8;
        ep++;
      end
    end
    res = {x[11], 3'(ep), 4'(fr)};
  endfunction

  // Waits (from a negedge) for the next grant; returns at the negedge after its acceptance edge.
  task automatic next_grant(output int gid);
    gid = -1;
    for (int w = 0; w < 40; w++) begin
      #1;
      if (bus.req_ready != '0) begin
        for (int b = 0; b < N_REQ; b++) if (bus.req_ready[b]) gid = b;
        if (!$onehot(bus.req_ready)) gid = -2;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  // One request from requester id with out_ready=1; lat counts edges after the acceptance edge.
  task automatic do_conv(input int id, input logic [11:0] x, output int lat,
                         output logic [7:0] res, output logic [IDW-1:0] rid, output bit ok);
    int g;
    ok = 1'b0;
    lat = 0;
    res = '0;
    rid = '0;
    @(negedge clk);
    bus.req_data[12*id +: 12] = x;
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    next_grant(g);
    bus.req_valid = '0;
    if (g != id) return;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (bus.out_valid !== 1'b1) return;
    res = {bus.out_s, bus.out_e, bus.out_f};
    rid = bus.out_id;
    ok  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.req_ready !== '0) begin
      bad++;
      $display("FAIL reset_req_ready got=%b want=0", bus.req_ready);
    end
    total++;
    if ({bus.out_valid, bus.out_s, bus.out_e, bus.out_f, bus.out_id} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b s=%b e=%0d f=%b id=%0d want all 0",
               bus.out_valid, bus.out_s, bus.out_e, bus.out_f, bus.out_id);
    end
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int g;
    int want[8] = '{0, 1, 2, 3, 0, 1, 3, 0};
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      bus.req_data  = {$urandom, $urandom};
      bus.req_valid = '1;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
        if (pass == 1 && n == 2) bus.req_valid = 4'b1001;
        next_grant(g);
        total++;
        if (g != want[pass*4 + n]) begin
          bad++;
          $display("FAIL rr_grant pass=%0d n=%0d got=%0d want=%0d", pass, n, g, want[pass*4 + n]);
        end
      end
      bus.req_valid = '0;
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic test_vectors();
    logic [11:0] xs[4]   = '{12'h07D, 12'h800, 12'h000, 12'hFFF};
    logic [7:0]  want[4] = '{8'b0_100_1000, 8'b1_111_1111, 8'b0_000_0000, 8'b1_000_0001};
`ifdef FPCONV_FAST_SCAN_EN
    int wlat[4] = '{3, 3, 3, 3};
`else
    int wlat[4] = '{7, 3, 10, 10};
`endif
    int lat;
    logic [7:0] res;
    logic [IDW-1:0] rid;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      do_conv(i, xs[i], lat, res, rid, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL vec_timeout x=%h got=no result want=result", xs[i]);
      end
      total++;
      if (res !== want[i]) begin
        bad++;
        $display("FAIL vec_result x=%h got=%b want=%b", xs[i], res, want[i]);
      end
      total++;
      if (rid !== IDW'(i)) begin
        bad++;
        $display("FAIL vec_id x=%h got=%0d want=%0d", xs[i], rid, i);
      end
      total++;
      if (lat != wlat[i]) begin
        bad++;
        $display("FAIL vec_latency x=%h got=%0d want=%0d", xs[i], lat, wlat[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g, id, lat, w;
    logic [11:0] x;
    logic [7:0] exp_res;
    logic [7:0] cap;
    logic [IDW-1:0] cap_id;
    @(negedge clk);
    bus.out_ready = 1'b0;
    id = int'($urandom_range(0, N_REQ - 1));
    x  = 12'($urandom);
    bus.req_data[12*id +: 12] = x;
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    next_grant(g);
    total++;
    if (g != id) begin
      bad++;
      $display("FAIL bp_grant got=%0d want=%0d", g, id);
    end
    bus.req_valid = '1;
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    model(x, exp_res, lat);
    cap    = {bus.out_s, bus.out_e, bus.out_f};
    cap_id = bus.out_id;
    total++;
    if (bus.out_valid !== 1'b1 || cap !== exp_res || cap_id !== IDW'(id)) begin
      bad++;
      $display("FAIL bp_result x=%h got v=%b res=%b id=%0d want v=1 res=%b id=%0d",
               x, bus.out_valid, cap, cap_id, exp_res, id);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || {bus.out_s, bus.out_e, bus.out_f} !== cap ||
          bus.out_id !== cap_id || bus.req_ready !== '0) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got v=%b res=%b id=%0d rdy=%b want v=1 res=%b id=%0d rdy=0",
                 c, bus.out_valid, {bus.out_s, bus.out_e, bus.out_f}, bus.out_id, bus.req_ready,
                 cap, cap_id);
      end
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_consume got v=%b want v=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    int g;
    bit seen;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.req_data[12*2 +: 12] = 12'h000;
    bus.req_valid = 4'b0100;
    next_grant(g);
    bus.req_valid = '0;
    total++;
    if (g != 2) begin
      bad++;
      $display("FAIL abort_grant got=%0d want=2", g);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_no_result got out_valid=1 want 0");
    end
    bus.req_valid = '1;
    next_grant(g);
    bus.req_valid = '0;
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL abort_ptr_reset got=%0d want=0", g);
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_random();
    logic [11:0] edges[8] = '{12'h000, 12'h001, 12'hFFF, 12'h800, 12'h7FF, 12'h00F, 12'h010, 12'hFC1};
    int id, lat, wlat;
    logic [11:0] x;
    logic [7:0] res, exp_res;
    logic [IDW-1:0] rid;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      id = int'($urandom_range(0, N_REQ - 1));
      x  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 7)] : 12'($urandom);
      model(x, exp_res, wlat);
      do_conv(id, x, lat, res, rid, ok);
      total++;
      if (!ok || res !== exp_res) begin
        bad++;
        $display("FAIL rand_result x=%h ok=%0d got=%b want=%b", x, ok, res, exp_res);
      end
      total++;
      if (rid !== IDW'(id)) begin
        bad++;
        $display("FAIL rand_id x=%h got=%0d want=%0d", x, rid, id);
      end
      total++;
      if (lat != wlat) begin
        bad++;
        $display("FAIL rand_latency x=%h got=%0d want=%0d", x, lat, wlat);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_vectors();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
